// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the voltage-to-BCD stage
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_W       = 4;
  localparam int DIGITS      = 4;
  localparam int SHIFT_CNT   = 16;
  localparam int SAT_MAX_DEF = 9999;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3
  import adc_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_W'(5)) dout = din + BCD_W'(3);
  end

endmodule

// File: rtl/volt_bcd_conv.sv
// rtl/volt_bcd_conv.sv - sequential binary-to-BCD converter between voltage_convert and lcd_1602
// One capture edge, sixteen shift-add-3 edges, one output edge; a one-deep buffer holds a newer strobe.
module volt_bcd_conv
  import adc_pkg::*;
#(
  parameter int unsigned SAT_MAX = SAT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [15:0] voltage,
  input  logic       voltage_valid,
  output logic       busy,
  output logic       bcd_valid,
  output logic [3:0] bcd_thou,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       ovf
);

  localparam logic [15:0] SAT_V = 16'(SAT_MAX);
  localparam int ACC_W = BCD_W * DIGITS;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_adj;
  logic             ovf_pend_q, ovf_pend_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic             busy_q, busy_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [ACC_W-1:0] dig_q, dig_d;
  logic             ovf_q, ovf_d;

  logic             cap_en;
  logic [15:0]      cap_src;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc_q[g*BCD_W +: BCD_W]),
      .dout (acc_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    ovf_pend_d  = ovf_pend_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    busy_d      = busy_q;
    bcd_valid_d = 1'b0;
    dig_d       = dig_q;
    ovf_d       = ovf_q;
    cap_en      = 1'b0;
    cap_src     = voltage;

    case (state_q)
      IDLE: begin
        if (voltage_valid) cap_en = 1'b1;
      end
      SHIFT: begin
        if (voltage_valid) begin
          pend_d     = 1'b1;
          pend_val_d = voltage;
        end
        {acc_d, shreg_d} = {acc_adj[ACC_W-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CNT - 1)) state_d = DONE;
      end
      DONE: begin
        dig_d       = acc_q;
        ovf_d       = ovf_pend_q;
        bcd_valid_d = 1'b1;
        // A strobe landing on this very edge is newer than anything buffered.
        if (voltage_valid) begin
          cap_en = 1'b1;
          pend_d = 1'b0;
        end else if (pend_q) begin
          cap_en  = 1'b1;
          cap_src = pend_val_q;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (cap_en) begin
      state_d    = SHIFT;
      busy_d     = 1'b1;
      cnt_d      = 4'd0;
      acc_d      = '0;
      ovf_pend_d = (cap_src > SAT_V);
      shreg_d    = (cap_src > SAT_V) ? SAT_V : cap_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= '0;
      acc_q       <= '0;
      ovf_pend_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      dig_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      ovf_pend_q  <= ovf_pend_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      busy_q      <= busy_d;
      bcd_valid_q <= bcd_valid_d;
      dig_q       <= dig_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = bcd_valid_q;
  assign bcd_thou  = dig_q[15:12];
  assign bcd_hund  = dig_q[11:8];
  assign bcd_tens  = dig_q[7:4];
  assign bcd_ones  = dig_q[3:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_volt_bcd_conv.sv
// tb/tb_volt_bcd_conv.sv - directed-vector bench for volt_bcd_conv
module tb_volt_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] voltage = '0;
  logic        voltage_valid = 1'b0;
  logic        busy, bcd_valid, ovf;
  logic [3:0]  bcd_thou, bcd_hund, bcd_tens, bcd_ones;
  logic [15:0] dig;

  int n_vec = 0;
  int n_err = 0;

  volt_bcd_conv #(.SAT_MAX(9999)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .voltage       (voltage),
    .voltage_valid (voltage_valid),
    .busy          (busy),
    .bcd_valid     (bcd_valid),
    .bcd_thou      (bcd_thou),
    .bcd_hund      (bcd_hund),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;
  assign dig = {bcd_thou, bcd_hund, bcd_tens, bcd_ones};

  // Drives a strobe so that the next rising edge is E0; returns 1 time unit after E0.
  task automatic start(input logic [15:0] v);
    @(negedge clk);
    voltage       = v;
    voltage_valid = 1'b1;
    @(posedge clk);
    #1;
    voltage_valid = 1'b0;
  endtask

  // Counts edges until bcd_valid is seen (sampled 1 unit after each edge); 0 if never.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bcd_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, bcd_valid, ovf, dig} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", {busy, bcd_valid, ovf, dig}, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] vin [6];
    logic [15:0] vexp [6];
    logic        oexp [6];
    int lat;
    vin  = '{16'd330, 16'd0, 16'd9999, 16'd12345, 16'd42, 16'd65535};
    vexp = '{16'h0330, 16'h0000, 16'h9999, 16'h9999, 16'h0042, 16'h9999};
    oexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      start(vin[i]);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL basic_busy_after_e0[%0d]: got %b want 1", i, busy);
      end
      wait_done(lat);
      n_vec++;
      if (lat != 17) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: got %0d want 17", i, lat);
      end
      n_vec++;
      if (dig !== vexp[i]) begin
        n_err++;
        $display("FAIL basic_digits[%0d]: got %h want %h", i, dig, vexp[i]);
      end
      n_vec++;
      if (ovf !== oexp[i]) begin
        n_err++;
        $display("FAIL basic_ovf[%0d]: got %b want %b", i, ovf, oexp[i]);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({bcd_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL basic_strobe_width[%0d]: got valid,busy=%b want 00", i, {bcd_valid, busy});
      end
    end
  endtask

  task automatic test_hold;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if ({bcd_valid, ovf, dig} !== {1'b0, 1'b1, 16'h9999}) begin
      n_err++;
      $display("FAIL hold_outputs: got %h want %h", {bcd_valid, ovf, dig}, {1'b0, 1'b1, 16'h9999});
    end
  endtask

  task automatic test_back_to_back;
    start(16'd111);
    for (int e = 1; e <= 34; e++) begin
      voltage_valid = (e == 5 || e == 9);
      voltage       = (e == 5) ? 16'd222 : 16'd333;
      @(posedge clk);
      #1;
      voltage_valid = 1'b0;
      if (e <= 33) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_busy[E%0d]: got %b want 1", e, busy);
        end
      end
      n_vec++;
      if (e == 17 || e == 34) begin
        if (bcd_valid !== 1'b1 || dig !== ((e == 17) ? 16'h0111 : 16'h0333)) begin
          n_err++;
          $display("FAIL b2b_output[E%0d]: got valid=%b dig=%h want valid=1 dig=%h",
                   e, bcd_valid, dig, (e == 17) ? 16'h0111 : 16'h0333);
        end
      end else if (bcd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_spurious_valid[E%0d]: got %b want 0", e, bcd_valid);
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_strobe_at_done;
    int lat;
    start(16'd1234);
    repeat (16) @(posedge clk);
    #1;
    voltage       = 16'd5678;
    voltage_valid = 1'b1;
    @(posedge clk);
    #1;
    voltage_valid = 1'b0;
    n_vec++;
    if ({bcd_valid, busy, dig} !== {2'b11, 16'h1234}) begin
      n_err++;
      $display("FAIL done_strobe_first: got %h want %h", {bcd_valid, busy, dig}, {2'b11, 16'h1234});
    end
    wait_done(lat);
    n_vec++;
    if (lat != 17 || dig !== 16'h5678) begin
      n_err++;
      $display("FAIL done_strobe_second: got lat=%0d dig=%h want lat=17 dig=5678", lat, dig);
    end
  endtask

  task automatic test_abort;
    int lat;
    start(16'd500);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, bcd_valid, ovf, dig} !== 19'd0) begin
      n_err++;
      $display("FAIL abort_immediate: got %h want %h", {busy, bcd_valid, ovf, dig}, 19'd0);
    end
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, bcd_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_held: got %b want 00", {busy, bcd_valid});
    end
    @(negedge clk);
    rst_n         = 1'b1;
    voltage       = 16'd77;
    voltage_valid = 1'b1;
    @(posedge clk);
    #1;
    voltage_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_first_edge_capture: got busy=%b want 1", busy);
    end
    wait_done(lat);
    n_vec++;
    if (lat != 17 || dig !== 16'h0077 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recover: got lat=%0d dig=%h ovf=%b want lat=17 dig=0077 ovf=0", lat, dig, ovf);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_back_to_back;
    test_strobe_at_done;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
